// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int unsigned DIV_W_DEFAULT = 8;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned W = 8
) (
  input  logic [W:0]   p_i,
  input  logic         q_msb_i,
  input  logic [W-1:0] b_i,
  output logic [W:0]   p_o,
  output logic         q_bit_o
);

  logic [W+1:0] shifted;
  logic [W+1:0] trial;

  // One extra bit of headroom lets the borrow be read straight off the MSB.
  always_comb begin
    shifted = {p_i, q_msb_i};
    trial   = shifted - {2'b00, b_i};
    if (trial[W+1]) begin
      p_o     = shifted[W:0];
      q_bit_o = 1'b0;
    end else begin
      p_o     = trial[W:0];
      q_bit_o = 1'b1;
    end
  end

endmodule

// File: rtl/division_sequencer.sv
// Sequential restoring divider: one quotient bit per clock behind a start/busy/done handshake.
module division_sequencer
  import div_pkg::*;
#(
  parameter int unsigned N = DIV_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic         result_valid,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int unsigned CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  div_state_t       state_q, state_d;
  logic [N-1:0]     qs_q, qs_d;
  logic [N-1:0]     bs_q, bs_d;
  logic [N:0]       p_q, p_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     quotient_q, quotient_d;
  logic [N-1:0]     remainder_q, remainder_d;
  logic             result_valid_q, result_valid_d;
  logic             div_by_zero_q, div_by_zero_d;

  logic [N:0]       p_next;
  logic             q_bit;
  logic             accept;

  div_step #(.W(N)) u_step (
    .p_i     (p_q),
    .q_msb_i (qs_q[N-1]),
    .b_i     (bs_q),
    .p_o     (p_next),
    .q_bit_o (q_bit)
  );

  always_comb begin
    state_d        = state_q;
    qs_d           = qs_q;
    bs_d           = bs_q;
    p_d            = p_q;
    cnt_d          = cnt_q;
    quotient_d     = quotient_q;
    remainder_d    = remainder_q;
    result_valid_d = result_valid_q;
    div_by_zero_d  = div_by_zero_q;
    accept         = 1'b0;

    case (state_q)
      IDLE: accept = start;
      RUN: begin
        qs_d = {qs_q[N-2:0], q_bit};
        p_d  = p_next;
        if (cnt_q == CNT_LAST) begin
          quotient_d     = {qs_q[N-2:0], q_bit};
          remainder_d    = p_next[N-1:0];
          result_valid_d = 1'b1;
          state_d        = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        accept  = start;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A zero divisor completes on the accepting edge itself, skipping RUN.
    if (accept) begin
      qs_d           = dividend;
      bs_d           = divisor;
      p_d            = '0;
      cnt_d          = '0;
      result_valid_d = 1'b0;
      div_by_zero_d  = 1'b0;
      if (divisor == '0) begin
        quotient_d     = '1;
        remainder_d    = dividend;
        div_by_zero_d  = 1'b1;
        result_valid_d = 1'b1;
        state_d        = DONE;
      end else begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      qs_q           <= '0;
      bs_q           <= '0;
      p_q            <= '0;
      cnt_q          <= '0;
      quotient_q     <= '0;
      remainder_q    <= '0;
      result_valid_q <= 1'b0;
      div_by_zero_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      qs_q           <= qs_d;
      bs_q           <= bs_d;
      p_q            <= p_d;
      cnt_q          <= cnt_d;
      quotient_q     <= quotient_d;
      remainder_q    <= remainder_d;
      result_valid_q <= result_valid_d;
      div_by_zero_q  <= div_by_zero_d;
    end
  end

  assign busy         = (state_q == RUN);
  assign done         = (state_q == DONE);
  assign result_valid = result_valid_q;
  assign quotient     = quotient_q;
  assign remainder    = remainder_q;
  assign div_by_zero  = div_by_zero_q;

endmodule
